truth_table_sweeper: RTL and testbench

//   Sequential stimulus generator and checker for a 3-input, 1-output combinational stage.
//   On start, drives every {A,B,C} vector 3'b000..3'b111 (A = MSB) into the stage.

---
 rtl/truth_table_sweeper_if.sv | 43 ++++
 rtl/truth_table_sweeper.sv | 119 +++++++++++
 tb/tb_truth_table_sweeper.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the truth-table sweeper and the
// combinational stage it drives, plus the sweep status outputs.
interface truth_table_sweeper_if;
  logic       start;
  logic       F;
  logic       A;
  logic       B;
  logic       C;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] error_count;
  logic [2:0] first_fail;
  logic       fail_valid;

  modport master (
    input  start,
    input  F,
    output A,
    output B,
    output C,
    output busy,
    output done,
    output pass,
    output error_count,
    output first_fail,
    output fail_valid
  );

  modport slave (
    output start,
    output F,
    input  A,
    input  B,
    input  C,
    input  busy,
    input  done,
    input  pass,
    input  error_count,
    input  first_fail,
    input  fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks {A,B,C} through 000..111, holds each vector, then samples F
// against a parameterised truth table and reports the mismatch summary.
module truth_table_sweeper #(
  parameter logic [7:0] EXPECTED      = 8'b1101_1111,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  truth_table_sweeper_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [2:0] idx, idx_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] err, err_d;
  logic [2:0] ff, ff_d;
  logic       fv, fv_d;
  logic       done, done_d;
  logic       pass, pass_d;
  logic       busy, busy_d;
  logic       mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= '0;
      ff    <= '0;
      fv    <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      err   <= err_d;
      ff    <= ff_d;
      fv    <= fv_d;
      done  <= done_d;
      pass  <= pass_d;
      busy  <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    err_d   = err;
    ff_d    = ff;
    fv_d    = fv;
    done_d  = done;
    pass_d  = pass;
    busy_d  = busy;
    mis     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt + 4'd1;
        if (cnt == SETTLE_LAST)
          state_d = SAMPLE;
      end
      SAMPLE: begin
        // X/Z on F must count as a mismatch, hence the case inequality
        mis = (bus.F !== EXPECTED[idx]);
        if (mis) begin
          err_d = err + 4'd1;
          if (!fv) begin
            ff_d = idx;
            fv_d = 1'b1;
          end
        end
        if (idx == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          idx_d   = idx + 3'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {bus.A, bus.B, bus.C} = idx;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.error_count = err;
  assign bus.first_fail  = ff;
  assign bus.fail_valid  = fv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: scoreboarded sweeps with correct, stuck-1 and stuck-0
// stage models, mid-sweep reset and held-high start.
module tb_truth_table_sweeper;

  typedef struct {
    logic [3:0] ec;
    logic [2:0] ff;
    logic       fv;
    logic       ps;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] tt;
  int         checks;
  int         errors;
  exp_t       sb[$];

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(
    .EXPECTED      (8'b1101_1111),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] abc;
  assign abc = {bus.A, bus.B, bus.C};

  // mode 0: correct stage, 1: stuck at 1, 2: stuck at 0
  always_comb begin
    bus.F = 1'b0;
    case (mode)
      2'd0:    bus.F = tt[abc];
      2'd1:    bus.F = 1'b1;
      default: bus.F = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [1:0] m);
    exp_t e;
    logic f;
    e.ec = '0;
    e.ff = '0;
    e.fv = 1'b0;
    for (int v = 0; v < 8; v++) begin
      f = (m == 2'd0) ? tt[v] : (m == 2'd1);
      if (f != tt[v]) begin
        if (!e.fv) begin
          e.ff = 3'(v);
          e.fv = 1'b1;
        end
        e.ec = e.ec + 4'd1;
      end
    end
    e.ps = (e.ec == 4'd0);
    return e;
  endfunction

  // drive: raise start at a negedge; otherwise start is already held high
  task automatic sweep(input bit drive, input bit keep_start);
    exp_t e;
    if (drive) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    sb.push_back(predict(mode));
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        if (!keep_start) bus.start = 1'b0;
        check("start_busy", 8'(bus.busy), 8'd1);
        check("start_done", 8'(bus.done), 8'd0);
        check("start_ec", 8'(bus.error_count), 8'd0);
      end
      if (k < 24) begin
        check("vector", 8'(abc), 8'(k / 3));
        if (bus.done !== 1'b0) check("early_done", 8'(bus.done), 8'd0);
      end else begin
        check("done_24", 8'(bus.done), 8'd1);
        check("busy_end", 8'(bus.busy), 8'd0);
      end
    end
    if (sb.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      check("error_count", 8'(bus.error_count), 8'(e.ec));
      check("fail_valid", 8'(bus.fail_valid), 8'(e.fv));
      check("pass", 8'(bus.pass), 8'(e.ps));
      if (e.fv) check("first_fail", 8'(bus.first_fail), 8'(e.ff));
    end
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    tt        = 8'b1101_1111;
    mode      = 2'd0;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_abc", 8'(abc), 8'd0);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_done", 8'(bus.done), 8'd0);
    check("rst_pass", 8'(bus.pass), 8'd0);
    check("rst_ec", 8'(bus.error_count), 8'd0);
    check("rst_ff", 8'(bus.first_fail), 8'd0);
    check("rst_fv", 8'(bus.fail_valid), 8'd0);

    mode = 2'd0;
    sweep(1'b1, 1'b0);
    mode = 2'd1;
    sweep(1'b1, 1'b0);
    check("stuck1_ec", 8'(bus.error_count), 8'd1);
    check("stuck1_ff", 8'(bus.first_fail), 8'd5);
    mode = 2'd2;
    sweep(1'b1, 1'b0);
    check("stuck0_ec", 8'(bus.error_count), 8'd7);
    check("stuck0_ff", 8'(bus.first_fail), 8'd0);

    // mid-sweep abort, with errors already accumulated by vector 011
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (abc != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_011", 8'(abc), 8'd3);
    check("pre_rst_ec", 8'(bus.error_count), 8'd3);
    reset = 1'b1;
    #1;
    check("arst_busy", 8'(bus.busy), 8'd0);
    check("arst_done", 8'(bus.done), 8'd0);
    check("arst_ec", 8'(bus.error_count), 8'd0);
    check("arst_abc", 8'(abc), 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mode  = 2'd0;
    sweep(1'b1, 1'b0);

    // start held high: restart right after done, no effect while busy
    sweep(1'b1, 1'b1);
    sweep(1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("held_final_done", 8'(bus.done), 8'd1);
    check("held_final_pass", 8'(bus.pass), 8'd1);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
